// File: rtl/modular_counter_updown.sv
// Modulo-N up/down digit counter with tick carry/borrow, preset and set-button adjust.
// Define MODCNT_AUTOREPEAT_EN to build the press/hold/auto-repeat adjust FSM; otherwise one step per press.
module modular_counter_updown #(
    parameter int WIDTH      = 4,
    parameter int MODULO     = 10,
    parameter int N_ADJ      = 2,
    parameter int HOLD_CYC   = 500,
    parameter int REPEAT_CYC = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [N_ADJ-1:0] adj_up,
    input  logic [N_ADJ-1:0] adj_dn,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             borrow,
    output logic             adj_active
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    if (MODULO < 2 || MODULO > (1 << WIDTH) || N_ADJ < 1 ||
        HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cfg
        $error("modular_counter_updown: illegal parameter set");
    end

    function automatic logic [WIDTH-1:0] wrap_inc(input logic [WIDTH-1:0] v);
        return (v == MAX_VAL) ? '0 : v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] wrap_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? MAX_VAL : v - WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return ({1'b0, v} < MOD_EXT) ? v : '0;
    endfunction

    logic up_any;
    logic dn_any;
    logic up_prev;
    logic dn_prev;
    logic armed;
    logic up_rise;
    logic dn_rise;
    logic lone_up;
    logic lone_dn;
    logic man_step;
    logic man_up;
    logic tick_ok;
    logic [WIDTH-1:0] count_next;

    assign up_any = |adj_up;
    assign dn_any = |adj_dn;

    // armed blocks the first cycle after reset so a button held through reset needs a fresh press
    assign up_rise = armed & up_any & ~up_prev;
    assign dn_rise = armed & dn_any & ~dn_prev;
    assign lone_up = up_rise & ~dn_any;
    assign lone_dn = dn_rise & ~up_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up_prev <= 1'b0;
            dn_prev <= 1'b0;
            armed   <= 1'b0;
        end else begin
            up_prev <= up_any;
            dn_prev <= dn_any;
            armed   <= 1'b1;
        end
    end

`ifdef MODCNT_AUTOREPEAT_EN
    localparam int TMR_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] RPT_LD  = TMR_W'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } adj_state_t;

    adj_state_t       state;
    logic [TMR_W-1:0] timer;
    logic             dir_up;
    logic             held;

    assign held = dir_up ? up_any : dn_any;

    always_comb begin
        man_step = 1'b0;
        man_up   = dir_up;
        case (state)
            IDLE: begin
                man_step = lone_up | lone_dn;
                man_up   = lone_up;
            end
            HOLD, RPT: man_step = held && (timer == '0);
            default: man_step = 1'b0;
        endcase
    end

    // the opposite direction is never looked at once a press is latched
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            dir_up     <= 1'b0;
            adj_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (lone_up || lone_dn) begin
                        dir_up     <= lone_up;
                        timer      <= HOLD_LD;
                        state      <= HOLD;
                        adj_active <= 1'b1;
                    end
                end
                HOLD, RPT: begin
                    if (!held) begin
                        state      <= IDLE;
                        adj_active <= 1'b0;
                    end else if (timer == '0) begin
                        timer <= RPT_LD;
                        state <= RPT;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    adj_active <= 1'b0;
                end
            endcase
        end
    end
`else
    assign man_step   = lone_up | lone_dn;
    assign man_up     = lone_up;
    assign adj_active = 1'b0;
`endif

    always_comb begin
        count_next = count;
        if (load) begin
            count_next = clamp_load(load_value);
        end else if (man_step) begin
            count_next = man_up ? wrap_inc(count) : wrap_dec(count);
        end else if (enable) begin
            count_next = up_dn ? wrap_inc(count) : wrap_dec(count);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // only a tick that actually takes effect may ripple into the next digit
    assign tick_ok = reset_n & enable & ~load & ~man_step;
    assign carry   = tick_ok &  up_dn & (count == MAX_VAL);
    assign borrow  = tick_ok & ~up_dn & (count == '0);

endmodule

// File: tb/tb_modular_counter_updown.sv
// Scoreboard bench for modular_counter_updown: a MODULO=10 instance driven against a behavioural
// model, plus MODULO=60 and MODULO=16 instances checked against fixed expectations.
module tb_modular_counter_updown;

    localparam int HOLD  = 5;
    localparam int REP   = 3;
    localparam int MOD_A = 10;

`ifdef MODCNT_AUTOREPEAT_EN
    localparam int HOLD_UP_END = 4;
    localparam int HOLD_DN_END = 7;
`else
    localparam int HOLD_UP_END = 1;
    localparam int HOLD_DN_END = 2;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic       en_a, ud_a, ld_a;
    logic [3:0] lv_a;
    logic [1:0] au_a, ad_a;
    logic [3:0] cnt_a;
    logic       carry_a, borrow_a, act_a;

    logic       en_b, ud_b, ld_b;
    logic [5:0] lv_b;
    logic [0:0] au_b, ad_b;
    logic [5:0] cnt_b;
    logic       carry_b, borrow_b, act_b;

    logic       en_c, ud_c, ld_c;
    logic [3:0] lv_c;
    logic [0:0] au_c, ad_c;
    logic [3:0] cnt_c;
    logic       carry_c, borrow_c, act_c;

    modular_counter_updown #(.WIDTH(4), .MODULO(MOD_A), .N_ADJ(2), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .up_dn(ud_a), .load(ld_a), .load_value(lv_a),
        .adj_up(au_a), .adj_dn(ad_a), .count(cnt_a), .carry(carry_a), .borrow(borrow_a), .adj_active(act_a)
    );

    modular_counter_updown #(.WIDTH(6), .MODULO(60), .N_ADJ(1), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(en_b), .up_dn(ud_b), .load(ld_b), .load_value(lv_b),
        .adj_up(au_b), .adj_dn(ad_b), .count(cnt_b), .carry(carry_b), .borrow(borrow_b), .adj_active(act_b)
    );

    modular_counter_updown #(.WIDTH(4), .MODULO(16), .N_ADJ(1), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut_c (
        .clk(clk), .reset_n(reset_n), .enable(en_c), .up_dn(ud_c), .load(ld_c), .load_value(lv_c),
        .adj_up(au_c), .adj_dn(ad_c), .count(cnt_c), .carry(carry_c), .borrow(borrow_c), .adj_active(act_c)
    );

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    typedef struct {
        int count;
        int carry;
        int borrow;
        int active;
    } exp_t;

    exp_t sb_q[$];

    task automatic sb_compare(input string tag, input int got_cnt, input int got_carry,
                              input int got_borrow, input int got_act);
        exp_t e;
        e = sb_q.pop_front();
        check({tag, "_count"},  got_cnt,    e.count);
        check({tag, "_carry"},  got_carry,  e.carry);
        check({tag, "_borrow"}, got_borrow, e.borrow);
        check({tag, "_active"}, got_act,    e.active);
    endtask

    // behavioural model of instance A
    int   m_count;
    logic m_up_prev, m_dn_prev, m_primed;
    int   m_active;
    int   m_age;

    task automatic model_reset();
        m_count   = 0;
        m_up_prev = 1'b0;
        m_dn_prev = 1'b0;
        m_primed  = 1'b0;
        m_active  = 0;
        m_age     = 0;
    endtask

    task automatic step_a(input logic en, input logic ud, input logic ld, input int lv,
                          input logic [1:0] au, input logic [1:0] ad, input string tag);
        exp_t e;
        logic ua, da, ur, dr, man, mup;
        logic c_s, b_s;
        en_a = en; ud_a = ud; ld_a = ld; lv_a = 4'(lv); au_a = au; ad_a = ad;
        ua  = |au;
        da  = |ad;
        ur  = m_primed & ua & ~m_up_prev;
        dr  = m_primed & da & ~m_dn_prev;
        man = 1'b0;
        mup = 1'b0;
`ifdef MODCNT_AUTOREPEAT_EN
        if (m_active == 0) begin
            if (ur && !da) begin
                man = 1'b1; mup = 1'b1; m_active = 1; m_age = 0;
            end else if (dr && !ua) begin
                man = 1'b1; mup = 1'b0; m_active = 2; m_age = 0;
            end
        end else if ((m_active == 1 && !ua) || (m_active == 2 && !da)) begin
            m_active = 0;
        end else begin
            m_age++;
            mup = (m_active == 1);
            if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0)) man = 1'b1;
        end
        e.active = (m_active != 0) ? 1 : 0;
`else
        if (ur && !da) begin
            man = 1'b1; mup = 1'b1;
        end else if (dr && !ua) begin
            man = 1'b1; mup = 1'b0;
        end
        e.active = 0;
`endif
        e.carry  = (en && ud && m_count == MOD_A - 1 && !ld && !man) ? 1 : 0;
        e.borrow = (en && !ud && m_count == 0 && !ld && !man) ? 1 : 0;
        if (ld)       m_count = (lv < MOD_A) ? lv : 0;
        else if (man) m_count = mup ? (m_count + 1) % MOD_A : (m_count + MOD_A - 1) % MOD_A;
        else if (en)  m_count = ud ? (m_count + 1) % MOD_A : (m_count + MOD_A - 1) % MOD_A;
        e.count   = m_count;
        m_up_prev = ua;
        m_dn_prev = da;
        m_primed  = 1'b1;
        sb_q.push_back(e);
        #2;
        c_s = carry_a;
        b_s = borrow_a;
        @(posedge clk);
        #1;
        sb_compare(tag, int'(cnt_a), int'(c_s), int'(b_s), int'(act_a));
        @(negedge clk);
    endtask

    // which: 0 = instance B (MODULO 60), 1 = instance C (MODULO 16)
    task automatic step_bc(input int which, input logic en, input logic ud, input logic ld, input int lv,
                           input int exp_cnt, input int exp_carry, input int exp_borrow, input string tag);
        exp_t e;
        logic c_s, b_s;
        e.count = exp_cnt; e.carry = exp_carry; e.borrow = exp_borrow; e.active = 0;
        sb_q.push_back(e);
        if (which == 0) begin
            en_b = en; ud_b = ud; ld_b = ld; lv_b = 6'(lv);
        end else begin
            en_c = en; ud_c = ud; ld_c = ld; lv_c = 4'(lv);
        end
        #2;
        c_s = (which == 0) ? carry_b : carry_c;
        b_s = (which == 0) ? borrow_b : borrow_c;
        @(posedge clk);
        #1;
        if (which == 0) sb_compare(tag, int'(cnt_b), int'(c_s), int'(b_s), int'(act_b));
        else            sb_compare(tag, int'(cnt_c), int'(c_s), int'(b_s), int'(act_c));
        @(negedge clk);
        en_b = 1'b0; ud_b = 1'b0; ld_b = 1'b0;
        en_c = 1'b0; ud_c = 1'b0; ld_c = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        en_a = 1'b0; ud_a = 1'b0; ld_a = 1'b0; lv_a = '0; au_a = '0; ad_a = '0;
        en_b = 1'b0; ud_b = 1'b0; ld_b = 1'b0; lv_b = '0; au_b = '0; ad_b = '0;
        en_c = 1'b0; ud_c = 1'b0; ld_c = 1'b0; lv_c = '0; au_c = '0; ad_c = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_count_a", int'(cnt_a), 0);
        check("reset_active_a", int'(act_a), 0);
        check("reset_count_b", int'(cnt_b), 0);
        reset_n = 1'b1;

        step_a(0, 0, 0, 0, 2'b00, 2'b00, "idle");
        for (int i = 0; i < 10; i++) step_a(1, 1, 0, 0, 2'b00, 2'b00, "up_tick");
        check("up_ten_ticks_final", int'(cnt_a), 0);
        for (int i = 0; i < 3; i++) step_a(1, 0, 0, 0, 2'b00, 2'b00, "dn_tick");
        check("dn_three_ticks_final", int'(cnt_a), 7);

        step_a(0, 0, 1, 9, 2'b00, 2'b00, "load9");
        step_a(1, 1, 1, 4, 2'b00, 2'b00, "load_over_tick");
        check("load_over_tick_final", int'(cnt_a), 4);
        step_a(0, 0, 1, 12, 2'b00, 2'b00, "load_out_of_range");
        check("load_out_of_range_final", int'(cnt_a), 0);

        step_a(0, 0, 1, 9, 2'b00, 2'b00, "load9b");
        step_a(1, 1, 0, 0, 2'b01, 2'b00, "man_over_tick");
        check("man_over_tick_final", int'(cnt_a), 0);
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "release1");
        step_a(0, 0, 0, 0, 2'b01, 2'b10, "both_rise");
        check("both_rise_final", int'(cnt_a), 0);
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "release2");

        step_a(0, 0, 1, 0, 2'b00, 2'b00, "load0");
        for (int i = 0; i < 12; i++) step_a(0, 0, 0, 0, 2'b10, 2'b00, "hold_up");
        check("hold_up_final", int'(cnt_a), HOLD_UP_END);
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "hold_up_release");
        check("hold_up_release_active", int'(act_a), 0);

        step_a(0, 0, 1, 3, 2'b00, 2'b00, "load3");
        for (int i = 0; i < 20; i++) step_a(0, 0, 0, 0, 2'b00, 2'b01, "hold_dn");
        check("hold_dn_final", int'(cnt_a), HOLD_DN_END);
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "hold_dn_release");

        step_a(0, 0, 1, 0, 2'b00, 2'b00, "load0b");
        step_a(0, 0, 0, 0, 2'b00, 2'b10, "man_dn_wrap");
        check("man_dn_wrap_final", int'(cnt_a), 9);
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "release3");

        for (int i = 0; i < 8; i++)
            step_a((i % 2) == 1, 1, 0, 0, 2'b01, (i >= 3) ? 2'b01 : 2'b00, "hold_with_opposite");
        for (int i = 0; i < 3; i++) step_a(0, 0, 0, 0, 2'b00, 2'b01, "opposite_left_held");
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "release4");

        step_bc(0, 1, 0, 0, 0, 59, 0, 1, "b_dn_wrap");
        step_bc(0, 0, 0, 1, 61, 0, 0, 0, "b_load_out_of_range");
        step_bc(0, 0, 0, 1, 59, 59, 0, 0, "b_load59");
        step_bc(0, 1, 1, 0, 0, 0, 1, 0, "b_up_wrap");
        step_bc(1, 0, 0, 1, 15, 15, 0, 0, "c_load15");
        step_bc(1, 1, 1, 0, 0, 0, 1, 0, "c_up_wrap");
        step_bc(1, 1, 0, 0, 0, 15, 0, 1, "c_dn_wrap");
        step_bc(1, 1, 1, 1, 7, 7, 0, 0, "c_load_over_tick");

        step_a(0, 0, 1, 5, 2'b00, 2'b00, "load5");
        for (int i = 0; i < 3; i++) step_a(0, 0, 0, 0, 2'b01, 2'b00, "pre_reset_hold");
        en_a = 1'b1; ud_a = 1'b0; ld_a = 1'b0; au_a = 2'b01; ad_a = 2'b00;
        reset_n = 1'b0;
        #2;
        check("async_reset_count", int'(cnt_a), 0);
        check("borrow_gated_in_reset", int'(borrow_a), 0);
        check("async_reset_active", int'(act_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) step_a(0, 0, 0, 0, 2'b01, 2'b00, "held_through_reset");
        check("held_through_reset_final", int'(cnt_a), 0);
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "release5");
        step_a(0, 0, 0, 0, 2'b01, 2'b00, "repress_after_reset");
        check("repress_after_reset_final", int'(cnt_a), 1);
        step_a(0, 0, 0, 0, 2'b00, 2'b00, "release6");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
